// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } ps2_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus a debounce counter for one PS/2 pin.
// The filtered level only moves after FILTER_LEN consecutive differing samples.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic res,
  input  logic raw,
  output logic filtered,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (res) begin
      sync_1   <= 1'b1;
      sync_2   <= 1'b1;
      filtered <= 1'b1;
      cnt      <= '0;
      fall     <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      fall   <= 1'b0;
      if (sync_2 == filtered) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        // Fall strobe coincides with the first cycle the filtered line reads 0.
        filtered <= sync_2;
        fall     <= filtered;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: filtered pins, frame checking, inactivity
// timeout, sticky error flags and a show-ahead receive FIFO.
//
// state | meaning
// IDLE  | waiting for a start bit; timeout counter held at 0
// SHIFT | collecting data, parity and stop bits on each clock fall
// CHECK | one cycle: validate stop/parity, push or flag the byte
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIMEOUT_US = 200,
  parameter int FILTER_LEN = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          ps2_clock,
  input  logic                          ps2_data,
  input  logic                          rd,
  output logic [PS2_DATA_BITS-1:0]      rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  input  logic                          err_clr,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          err_overflow
);

  localparam int TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW     = $clog2(TO_CYC + 1);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int SW     = PS2_FRAME_BITS - 1;

  logic strike;
  logic data_f;
  logic clock_f_unused;
  logic data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clock_filter (
    .clk      (clk),
    .res      (res),
    .raw      (ps2_clock),
    .filtered (clock_f_unused),
    .fall     (strike)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk      (clk),
    .res      (res),
    .raw      (ps2_data),
    .filtered (data_f),
    .fall     (data_fall_unused)
  );

  ps2_state_t      state_q, state_d;
  logic [SW-1:0]   shreg_q, shreg_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            push, pop, full;
  logic            set_parity, set_frame, set_overflow;

  logic [PS2_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]            wptr, rptr;

  assign rd_valid = (count != '0);
  assign full     = (count == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
  assign pop      = rd && rd_valid;
  assign rd_data  = rd_valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    to_cnt_d     = '0;
    push         = 1'b0;
    set_parity   = 1'b0;
    set_frame    = 1'b0;
    set_overflow = 1'b0;
    case (state_q)
      IDLE: begin
        if (strike) begin
          if (!data_f) begin
            state_d  = SHIFT;
            bitcnt_d = '0;
          end else begin
            set_frame = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (strike) begin
          shreg_d  = {data_f, shreg_q[SW-1:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'(PS2_FRAME_BITS - 2)) state_d = CHECK;
        end else if (to_cnt_q == TW'(TO_CYC)) begin
          set_frame = 1'b1;
          state_d   = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
        // shreg holds {stop, parity, data[7:0]}; odd parity over data+parity
        if (!shreg_q[SW-1])            set_frame    = 1'b1;
        else if (!(^shreg_q[SW-2:0]))  set_parity   = 1'b1;
        else if (full && !pop)         set_overflow = 1'b1;
        else                           push         = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= shreg_q[PS2_DATA_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      err_parity   <= 1'b0;
      err_frame    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_parity   <= (err_parity   && !err_clr) || set_parity;
      err_frame    <= (err_frame    && !err_clr) || set_frame;
      err_overflow <= (err_overflow && !err_clr) || set_overflow;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo at a scaled 1 MHz system clock so that
// 12.5 kHz PS/2 frames (80 cycles per bit) and a 200-cycle timeout stay short.
module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       res;
  logic       ps2_clock;
  logic       ps2_data;
  logic       rd;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] count;
  logic       err_clr;
  logic       err_parity;
  logic       err_frame;
  logic       err_overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .CLK_HZ     (1_000_000),
    .TIMEOUT_US (200),
    .FILTER_LEN (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk          (clk),
    .res          (res),
    .ps2_clock    (ps2_clock),
    .ps2_data     (ps2_data),
    .rd           (rd),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .err_clr      (err_clr),
    .err_parity   (err_parity),
    .err_frame    (err_frame),
    .err_overflow (err_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends the first nbits of {stop, par, d, start=0} LSB first. With glitch set,
  // a 2-cycle low pulse is put on the clock while it is high. With pop_at_push
  // set, rd is raised for exactly the CHECK cycle of the frame
  // (2 sync + 4 filter cycles to the strike, one more to enter CHECK).
  task automatic send(input logic [7:0] d, input logic par, input logic stop,
                      input int nbits, input bit glitch, input bit pop_at_push);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      if (glitch) begin
        repeat (8) @(negedge clk);
        ps2_clock = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clock = 1'b1;
        repeat (10) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      ps2_clock = 1'b0;
      if (pop_at_push && i == 10) begin
        repeat (7) @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        repeat (32) @(negedge clk);
      end else begin
        repeat (40) @(negedge clk);
      end
      ps2_clock = 1'b1;
      repeat (19) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d);
    send(d, ~^d, 1'b1, 11, 1'b0, 1'b0);
  endtask

  task automatic pulse_rd(input int n);
    @(negedge clk);
    rd = 1'b1;
    repeat (n) @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b1; ps2_clock = 1'b1; ps2_data = 1'b1; rd = 1'b0; err_clr = 1'b0;
    repeat (5) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    chk("rst_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_data", rd_data, 8'h00);
    chk("rst_errs", {err_parity, err_frame, err_overflow}, 3'b000);

    // single frame 0x1C, parity 0
    send(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    @(negedge clk);
    chk("f1_valid", rd_valid, 1);
    chk("f1_data", rd_data, 8'h1C);
    chk("f1_count", count, 1);
    chk("f1_errs", {err_parity, err_frame, err_overflow}, 3'b000);
    pulse_rd(1);
    chk("f1_pop_count", count, 0);

    // burst F0,1C then two reads and an extra read on empty
    send_good(8'hF0);
    send_good(8'h1C);
    @(negedge clk);
    chk("burst_count", count, 2);
    chk("burst_head0", rd_data, 8'hF0);
    pulse_rd(1);
    chk("burst_head1", rd_data, 8'h1C);
    pulse_rd(1);
    chk("burst_empty", rd_valid, 0);
    pulse_rd(1);
    chk("burst_underrun", count, 0);

    // bad parity
    send(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
    @(negedge clk);
    chk("par_count", count, 0);
    chk("par_flag", err_parity, 1);
    pulse_clr();
    chk("par_clr", err_parity, 0);

    // bad stop bit
    send(8'h1C, 1'b0, 1'b0, 11, 1'b0, 1'b0);
    @(negedge clk);
    chk("stop_frame", err_frame, 1);
    chk("stop_count", count, 0);
    pulse_clr();

    // timeout after start + 4 data bits
    send(8'h5A, 1'b1, 1'b1, 5, 1'b0, 1'b0);
    repeat (250) @(negedge clk);
    chk("to_frame", err_frame, 1);
    chk("to_count", count, 0);
    pulse_clr();
    chk("to_clr", err_frame, 0);
    send_good(8'h5A);
    @(negedge clk);
    chk("to_next_data", rd_data, 8'h5A);
    chk("to_next_count", count, 1);
    chk("to_next_errs", {err_parity, err_frame, err_overflow}, 3'b000);
    pulse_rd(1);

    // fill, overflow, then push+pop while full
    for (int k = 1; k <= 8; k++) begin
      logic [7:0] b;
      b = 8'(k);
      send_good(b);
    end
    @(negedge clk);
    chk("fill_count", count, 8);
    send_good(8'h55);
    @(negedge clk);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_count", count, 8);
    chk("ovf_head", rd_data, 8'h01);
    pulse_clr();
    send(8'h66, 1'b1, 1'b1, 11, 1'b0, 1'b1);
    @(negedge clk);
    chk("pp_flag", err_overflow, 0);
    chk("pp_count", count, 8);
    chk("pp_head", rd_data, 8'h02);
    pulse_rd(7);
    chk("pp_tail_count", count, 1);
    chk("pp_tail_data", rd_data, 8'h66);
    pulse_rd(1);
    chk("pp_drained", count, 0);

    // glitches on the clock line
    send(8'hA5, 1'b1, 1'b1, 11, 1'b1, 1'b0);
    @(negedge clk);
    chk("gl_data", rd_data, 8'hA5);
    chk("gl_count", count, 1);
    chk("gl_errs", {err_parity, err_frame, err_overflow}, 3'b000);

    // reset mid-frame with a byte queued and a flag set
    send(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
    @(negedge clk);
    chk("mr_pre_flag", err_parity, 1);
    send(8'h3C, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    res = 1'b1;
    repeat (3) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    chk("mr_valid", rd_valid, 0);
    chk("mr_count", count, 0);
    chk("mr_data", rd_data, 8'h00);
    chk("mr_errs", {err_parity, err_frame, err_overflow}, 3'b000);
    send_good(8'h1C);
    @(negedge clk);
    chk("mr_after_data", rd_data, 8'h1C);
    chk("mr_after_count", count, 1);
    chk("mr_after_errs", {err_parity, err_frame, err_overflow}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with a synchronizer, a glitch filter, full frame checking, an inactivity timeout and a show-ahead receive FIFO. It replaces the single-byte PS/2 receiver between the keyboard/mouse pins and the CPU-facing I/O port logic. It buffers bursts such as multi-byte scan codes, so software can poll at leisure. Every error is reported through sticky flags; no error is dropped silently.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz
- TIMEOUT_US, 200, maximum time between PS/2 clock falling edges inside a frame
- FILTER_LEN, 4, number of consecutive equal samples needed to accept a new PS/2 line level (≥1)
- FIFO_DEPTH, 8, receive FIFO entries (power of two, ≥2)
- clk  in  1  system clock; all logic on rising edge
- res  in  1  reset, synchronous, active-high
- ps2_clock  in  1  raw PS/2 CLOCK pin (asynchronous)
- ps2_data  in  1  raw PS/2 DATA pin (asynchronous)
- rd  in  1  pop strobe, one entry per cycle while high
- rd_data  out  8  FIFO head byte; valid when rd_valid=1
- rd_valid  out  1  FIFO not empty
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- err_clr  in  1  clears all sticky error flags
- err_parity  out  1  sticky: frame dropped for bad odd parity
- err_frame  out  1  sticky: bad start or stop bit, or timeout mid-frame
- err_overflow  out  1  sticky: good byte dropped because the FIFO was full

## Operation
- Input conditioning:
  - Each pin passes through a 2-FF synchronizer, then the filter.
  - The filtered level changes only after FILTER_LEN consecutive identical synchronized samples.
  - Filtered clock and data both reset to 1.
- A falling edge of the filtered clock (previous=1, current=0) is the sample strike. Data is sampled on the same cycle.
- FSM states:
  - IDLE: on a strike with data=0 (start bit), go to SHIFT with bitcnt=0. A strike with data=1 sets err_frame and stays in IDLE.
  - SHIFT: each strike shifts data in LSB-first and increments bitcnt. After the 10th strike after the start bit (8 data + parity + stop), go to CHECK.
  - CHECK (one cycle):
    - Stop bit must be 1; otherwise set err_frame.
    - If the stop bit is 1, the XOR of the 8 data bits and the parity bit must be 1; otherwise set err_parity.
    - If both checks pass: push when the FIFO is not full; when full, set err_overflow and drop the byte.
    - Always return to IDLE.
- Timeout:
  - Counter of TIMEOUT_CYC = CLK_HZ/1_000_000*TIMEOUT_US cycles.
  - Cleared on every strike and while in IDLE.
  - Reaching TIMEOUT_CYC in SHIFT sets err_frame, discards the partial byte and returns to IDLE.
- FIFO:
  - Show-ahead: rd_data always shows the oldest entry.
  - rd with rd_valid=0 is ignored; pointers are not modified.
  - Push and pop in the same cycle: both take effect and count is unchanged. This also applies when full: the pop frees the slot and the push is accepted without overflow.
- Sticky flags:
  - err_clr clears all three flags.
  - If err_clr and a new error occur in the same cycle, the new error wins and its flag stays set.
- Reset mid-frame: the FSM returns to IDLE, the partial byte is discarded and the FIFO empties.

## Timing
- Reset values:
  - rd_valid=0, count=0, rd_data=8'h00.
  - All err_* flags = 0.
  - FSM in IDLE; filtered lines at 1; timeout counter at 0.
- Pin-to-strike latency: 2 synchronizer cycles + FILTER_LEN cycles.
- Push latency: the byte is written the cycle after the stop-bit strike (CHECK cycle). rd_valid and count update on the next edge.
- rd is registered: rd_data shows the next entry and count decrements on the edge after rd.
- Error flags assert on the edge that ends CHECK, or on the timeout edge.
- Timeout counter width: $clog2(TIMEOUT_CYC+1).
- Pointer width: $clog2(FIFO_DEPTH); pointers wrap naturally.

## Structure
- Package ps2_pkg:
  - FSM state enum (IDLE, SHIFT, CHECK)
  - PS2_DATA_BITS=8
  - PS2_FRAME_BITS=11
- Sub-module ps2_line_filter:
  - One instance per pin: 2-FF synchronizer plus FILTER_LEN debounce counter.
  - Ports: clk, res, raw in, filtered out.
  - The clock instance also provides a fall strobe.
- The FIFO stays inline as a register array with read/write pointers.

## Test plan
- Send frame 0x1C with parity 0 and stop 1 at 12.5 kHz -> rd_valid=1, rd_data=8'h1C, count=1, all err_*=0.
- Send 0xF0, 0x1C back-to-back, then pulse rd twice -> reads 8'hF0 then 8'h1C, then rd_valid=0. Pulsing rd again leaves count at 0.
- Send 0x1C with parity 1 -> FIFO unchanged, err_parity=1. Pulse err_clr -> err_parity=0.
- Send start bit and 4 data bits, then hold clock high 250 µs -> err_frame=1, FIFO unchanged. A following good frame 0x5A is received correctly.
- Fill the FIFO with FIFO_DEPTH frames, then send one more -> err_overflow=1, count=FIFO_DEPTH, head unchanged. Repeat, pulsing rd in the push cycle -> no overflow, count stays FIFO_DEPTH.
- Inject 1-cycle glitches on ps2_clock shorter than FILTER_LEN during a frame -> byte received intact, no errors. Assert res mid-frame -> outputs return to reset values.
